bsg_manycore_host_req_arbiter: RTL and testbench

Shares the single host-side manycore request path between several host-side requesters, such as the DPI host FIFO, a profiler/print-stat injector and a trace dumper. Arbitration is round-robin. Each granted packet is captured into a one-entry holding register and presented to the host endpoint. Endpoint credits are reserved at grant time, so the number of outstanding requests never exceeds `max_credits_p`. A drain/fence sequencer lets the host wait until every issued request has been acknowledged, e.g. before finish or before asserting a reset.

---
 rtl/bsg_manycore_host_req_arbiter_if.sv | 38 +++
 rtl/bsg_manycore_host_req_arbiter.sv | 136 +++++++++++++
 tb/tb_bsg_manycore_host_req_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_host_req_arbiter_if.sv
// Bundle of requester, endpoint, credit and drain signals shared by the host
// request arbiter and whatever drives it.
interface bsg_manycore_host_req_arbiter_if #(
    parameter int num_req_p      = 2,
    parameter int packet_width_p = 128,
    parameter int max_credits_p  = 8
);
    localparam int credit_width_lp = $clog2(max_credits_p + 1);
    localparam int src_width_lp    = $clog2(num_req_p);

    logic [num_req_p-1:0]                req_v;
    logic [num_req_p*packet_width_p-1:0] req_packet;
    logic [num_req_p-1:0]                req_yumi;

    logic                                out_v;
    logic [packet_width_p-1:0]           out_packet;
    logic [src_width_lp-1:0]             out_src;
    logic                                out_ready;

    logic                                credit_return;
    logic [credit_width_lp-1:0]          credits;

    logic                                drain;
    logic                                drain_done;
    logic                                overflow;

    // Host side: drives requests, endpoint readiness, credit returns and drain.
    modport master (
        output req_v, req_packet, out_ready, credit_return, drain,
        input  req_yumi, out_v, out_packet, out_src, credits, drain_done, overflow
    );

    // Arbiter side.
    modport slave (
        input  req_v, req_packet, out_ready, credit_return, drain,
        output req_yumi, out_v, out_packet, out_src, credits, drain_done, overflow
    );
endinterface

// File: rtl/bsg_manycore_host_req_arbiter.sv
// Round-robin arbiter sharing the host manycore request path, with a one-entry
// holding register, grant-time credit reservation and a drain/fence sequencer.
//
// state | meaning
// IDLE  | holding register empty, may grant
// HOLD  | packet held toward endpoint, may grant back-to-back on out_ready
// DRAIN | granting stopped, waiting for all credits to come home
// DONE  | quiescent, drain_done asserted until drain drops
module bsg_manycore_host_req_arbiter #(
    parameter int num_req_p      = 2,
    parameter int packet_width_p = 128,
    parameter int max_credits_p  = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bsg_manycore_host_req_arbiter_if.slave bus
);
    localparam int credit_width_lp = $clog2(max_credits_p + 1);
    localparam int src_width_lp    = $clog2(num_req_p);

    localparam logic [credit_width_lp-1:0] max_credits_lc = credit_width_lp'(max_credits_p);
    localparam logic [src_width_lp-1:0]    last_src_lc    = src_width_lp'(num_req_p - 1);
    localparam logic [num_req_p-1:0]       one_hot_lc     = num_req_p'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                      state_r, state_n;
    logic [src_width_lp-1:0]     ptr_r, ptr_n;
    logic [credit_width_lp-1:0]  credits_r, credits_n;
    logic                        overflow_r, overflow_n;
    logic                        out_v_r;
    logic [packet_width_p-1:0]   out_packet_r;
    logic [src_width_lp-1:0]     out_src_r;
    logic                        drain_done_r;

    logic                        any_req;
    logic                        grant_slot;
    logic                        grant;
    logic [src_width_lp-1:0]     winner;

    // First valid requester at or after ptr, wrapping upward. Scanning from the
    // far end lets the nearest hit overwrite the result last.
    function automatic logic [src_width_lp-1:0] rr_pick(
        input logic [num_req_p-1:0]    v,
        input logic [src_width_lp-1:0] ptr
    );
        int idx;
        rr_pick = ptr;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % num_req_p;
            if (v[idx]) rr_pick = src_width_lp'(idx);
        end
    endfunction

    assign any_req    = |bus.req_v;
    assign winner     = rr_pick(bus.req_v, ptr_r);
    assign grant_slot = (state_r == IDLE) || ((state_r == HOLD) && bus.out_ready);

    // Reset gating keeps a requester from believing its packet was taken while
    // the holding register is being cleared.
    assign grant = reset_n_i && grant_slot && !bus.drain && (credits_r != '0) && any_req;

    assign bus.req_yumi = grant ? (one_hot_lc << winner) : '0;

    assign ptr_n = (winner == last_src_lc) ? '0 : winner + src_width_lp'(1);

    always_comb begin
        credits_n  = credits_r;
        overflow_n = overflow_r;
        if (grant && !bus.credit_return) begin
            credits_n = credits_r - credit_width_lp'(1);
        end else if (!grant && bus.credit_return) begin
            if (credits_r == max_credits_lc) overflow_n = 1'b1;
            else                             credits_n  = credits_r + credit_width_lp'(1);
        end
    end

    // DRAIN looks at next-cycle credits so drain_done rises right after the
    // final return lands.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE: begin
                if (bus.drain)  state_n = DRAIN;
                else if (grant) state_n = HOLD;
            end
            HOLD: begin
                if (bus.out_ready && !grant) state_n = bus.drain ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!bus.drain)                       state_n = IDLE;
                else if (credits_n == max_credits_lc) state_n = DONE;
            end
            DONE: begin
                if (!bus.drain) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            credits_r    <= max_credits_lc;
            overflow_r   <= 1'b0;
            out_v_r      <= 1'b0;
            out_packet_r <= '0;
            out_src_r    <= '0;
            drain_done_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            credits_r    <= credits_n;
            overflow_r   <= overflow_n;
            out_v_r      <= (state_n == HOLD);
            drain_done_r <= (state_n == DONE);
            if (grant) begin
                ptr_r        <= ptr_n;
                out_packet_r <= bus.req_packet[int'(winner)*packet_width_p +: packet_width_p];
                out_src_r    <= winner;
            end
        end
    end

    assign bus.out_v      = out_v_r;
    assign bus.out_packet = out_packet_r;
    assign bus.out_src    = out_src_r;
    assign bus.credits    = credits_r;
    assign bus.drain_done = drain_done_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// Directed bench: stimulus pushes the expected held packet into a queue and a
// separate monitor pops and compares on every endpoint handshake.
module tb_bsg_manycore_host_req_arbiter;
    localparam int num_req_p      = 2;
    localparam int packet_width_p = 128;
    localparam int max_credits_p  = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    logic [packet_width_p-1:0] pkt [num_req_p];
    int                        cnt [num_req_p];
    logic [packet_width_p:0]   exp_q [$];
    logic [packet_width_p-1:0] a5_pkt;

    always #5 clk = ~clk;

    bsg_manycore_host_req_arbiter_if #(
        .num_req_p(num_req_p), .packet_width_p(packet_width_p), .max_credits_p(max_credits_p)
    ) bus ();

    bsg_manycore_host_req_arbiter #(
        .num_req_p(num_req_p), .packet_width_p(packet_width_p), .max_credits_p(max_credits_p)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    function automatic logic [packet_width_p-1:0] make_pkt(input int i, input int c);
        make_pkt = {8'(i), 24'(c), {12{8'h3C}}};
    endfunction

    task automatic check(input string name, input logic [packet_width_p:0] act,
                         input logic [packet_width_p:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: drive inputs, verify the combinational yumi, queue the
    // expected capture, then advance past the edge.
    task automatic cycle(input logic [1:0] v, input logic rdy, input logic ret,
                         input logic drn, input logic [1:0] exp_y, input string tag);
        bus.req_v         = v;
        bus.out_ready     = rdy;
        bus.credit_return = ret;
        bus.drain         = drn;
        bus.req_packet    = {pkt[1], pkt[0]};
        #1;
        check({"yumi_", tag}, 129'(bus.req_yumi), 129'(exp_y));
        for (int i = 0; i < num_req_p; i++)
            if (exp_y[i]) exp_q.push_back({1'(i), pkt[i]});
        @(posedge clk);
        #1;
        for (int i = 0; i < num_req_p; i++)
            if (exp_y[i]) begin
                cnt[i]++;
                pkt[i] = make_pkt(i, cnt[i]);
            end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.out_v === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected actual=%0h required=none", {bus.out_src, bus.out_packet});
            end else begin
                check("out_src_packet", {bus.out_src, bus.out_packet}, exp_q.pop_front());
            end
        end
    end

    initial begin
        a5_pkt = {16{8'hA5}};
        for (int i = 0; i < num_req_p; i++) begin
            cnt[i] = 0;
            pkt[i] = make_pkt(i, 0);
        end
        reset_n           = 1'b0;
        bus.req_v         = '0;
        bus.req_packet    = '0;
        bus.out_ready     = 1'b0;
        bus.credit_return = 1'b0;
        bus.drain         = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_credits",    129'(bus.credits),    129'(8));
        check("rst_out_v",      129'(bus.out_v),      129'(0));
        check("rst_drain_done", 129'(bus.drain_done), 129'(0));
        check("rst_overflow",   129'(bus.overflow),   129'(0));
        check("rst_out_packet", 129'(bus.out_packet), 129'(0));
        check("rst_out_src",    129'(bus.out_src),    129'(0));

        // round-robin, one grant per cycle, returns one cycle behind
        cycle(2'b11, 1, 0, 0, 2'b01, "rr0");
        cycle(2'b11, 1, 1, 0, 2'b10, "rr1");
        cycle(2'b11, 1, 1, 0, 2'b01, "rr2");
        cycle(2'b11, 1, 1, 0, 2'b10, "rr3");
        cycle(2'b11, 1, 1, 0, 2'b01, "rr4");
        cycle(2'b11, 1, 1, 0, 2'b10, "rr5");
        cycle(2'b00, 1, 1, 0, 2'b00, "rr_end");
        check("rr_credits", 129'(bus.credits), 129'(8));
        check("rr_out_v",   129'(bus.out_v),   129'(0));

        // credit exhaustion
        for (int k = 0; k < 8; k++) cycle(2'b01, 1, 0, 0, 2'b01, "exh_grant");
        cycle(2'b01, 1, 0, 0, 2'b00, "exh_stall0");
        cycle(2'b01, 1, 0, 0, 2'b00, "exh_stall1");
        check("exh_credits0", 129'(bus.credits), 129'(0));
        cycle(2'b01, 1, 1, 0, 2'b00, "exh_ret");
        check("exh_credits1", 129'(bus.credits), 129'(1));
        cycle(2'b01, 1, 0, 0, 2'b01, "exh_one_more");
        cycle(2'b01, 1, 0, 0, 2'b00, "exh_stall2");
        check("exh_credits2", 129'(bus.credits), 129'(0));
        for (int k = 0; k < 8; k++) cycle(2'b00, 1, 1, 0, 2'b00, "exh_refill");
        check("exh_refilled", 129'(bus.credits), 129'(8));
        check("exh_no_ovf",   129'(bus.overflow), 129'(0));

        // backpressure on a held packet
        pkt[0] = a5_pkt;
        cycle(2'b01, 0, 0, 0, 2'b01, "bp_grant");
        for (int k = 0; k < 5; k++) begin
            check("bp_packet", 129'(bus.out_packet), 129'(a5_pkt));
            check("bp_credits", 129'(bus.credits), 129'(7));
            check("bp_out_v", 129'(bus.out_v), 129'(1));
            cycle(2'b01, 0, 0, 0, 2'b00, "bp_hold");
        end
        check("bp_packet_end", 129'(bus.out_packet), 129'(a5_pkt));
        cycle(2'b00, 1, 0, 0, 2'b00, "bp_release");
        cycle(2'b00, 0, 1, 0, 2'b00, "bp_ret");
        check("bp_credits_end", 129'(bus.credits), 129'(8));

        // drain with three outstanding
        for (int k = 0; k < 3; k++) cycle(2'b01, 1, 0, 0, 2'b01, "dr_grant");
        cycle(2'b01, 1, 0, 1, 2'b00, "dr_stop");
        check("dr_credits", 129'(bus.credits), 129'(5));
        cycle(2'b01, 1, 1, 1, 2'b00, "dr_r1");
        check("dr_done_a", 129'(bus.drain_done), 129'(0));
        cycle(2'b01, 1, 0, 1, 2'b00, "dr_gap1");
        check("dr_done_b", 129'(bus.drain_done), 129'(0));
        cycle(2'b01, 1, 1, 1, 2'b00, "dr_r2");
        check("dr_done_c", 129'(bus.drain_done), 129'(0));
        cycle(2'b01, 1, 0, 1, 2'b00, "dr_gap2");
        check("dr_done_d", 129'(bus.drain_done), 129'(0));
        cycle(2'b01, 1, 1, 1, 2'b00, "dr_r3");
        check("dr_done_rise", 129'(bus.drain_done), 129'(1));
        check("dr_credits_full", 129'(bus.credits), 129'(8));
        cycle(2'b01, 1, 0, 1, 2'b00, "dr_hold_done");
        check("dr_done_held", 129'(bus.drain_done), 129'(1));
        cycle(2'b01, 1, 0, 0, 2'b00, "dr_release");
        check("dr_done_fall", 129'(bus.drain_done), 129'(0));
        cycle(2'b01, 1, 0, 0, 2'b01, "dr_resume");
        cycle(2'b00, 1, 1, 0, 2'b00, "dr_flush");
        check("dr_credits_end", 129'(bus.credits), 129'(8));

        // simultaneous grant/return, then overflow
        cycle(2'b01, 1, 1, 0, 2'b01, "sim_full");
        check("sim_full_credits", 129'(bus.credits), 129'(8));
        check("sim_full_no_ovf", 129'(bus.overflow), 129'(0));
        cycle(2'b00, 1, 0, 0, 2'b00, "sim_pop0");
        cycle(2'b01, 1, 0, 0, 2'b01, "sim_g");
        cycle(2'b01, 1, 1, 0, 2'b01, "sim_gr");
        check("sim_credits", 129'(bus.credits), 129'(7));
        cycle(2'b00, 1, 1, 0, 2'b00, "sim_pop1");
        check("sim_credits_back", 129'(bus.credits), 129'(8));
        check("sim_no_ovf", 129'(bus.overflow), 129'(0));
        cycle(2'b00, 1, 1, 0, 2'b00, "ovf_ret");
        check("ovf_set", 129'(bus.overflow), 129'(1));
        check("ovf_credits_sat", 129'(bus.credits), 129'(8));
        cycle(2'b00, 1, 0, 0, 2'b00, "ovf_idle");
        check("ovf_sticky", 129'(bus.overflow), 129'(1));

        // reset mid-HOLD discards the held packet
        cycle(2'b01, 0, 0, 0, 2'b01, "pre_reset");
        check("pre_reset_out_v", 129'(bus.out_v), 129'(1));
        reset_n = 1'b0;
        exp_q.delete();
        cycle(2'b01, 0, 0, 0, 2'b00, "in_reset");
        check("mid_rst_out_v",    129'(bus.out_v),    129'(0));
        check("mid_rst_overflow", 129'(bus.overflow), 129'(0));
        check("mid_rst_credits",  129'(bus.credits),  129'(8));
        reset_n = 1'b1;
        cycle(2'b10, 1, 0, 0, 2'b10, "post_rst_ptr");
        cycle(2'b11, 1, 0, 0, 2'b01, "post_rst_wrap");
        cycle(2'b00, 1, 0, 0, 2'b00, "post_rst_pop");
        check("queue_drained", 129'(exp_q.size()), 129'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
